square_drawer: RTL and testbench

//  Consumer end of the square-coordinate interface: takes one square request
//  (top-left x, y, colour) per start pulse. Expands it into a raster of
//  per-pixel plot commands for the VGA adapter (x, y, colour, writeEn).

---
 rtl/square_drawer.sv | 149 ++++++++++++++
 tb/tb_square_drawer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/square_drawer.sv
// -----------------------------------------------------------------------------
// square_drawer
// Takes one square request (top-left x/y plus colour) per start and rasterises
// it into SQ_W*SQ_H per-pixel plot commands for the VGA adapter, x fastest.
//
// Ports
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-high
//   start          request strobe, taken in IDLE
//   square_x/y     top-left corner of the square (8 / 7 bits)
//   square_colour  RGB colour, 3'b000 erases
//   ready          high while idle
//   done           one-cycle pulse after the last pixel
//   vga_x/y        pixel coordinates for the adapter
//   vga_colour     pixel colour for the adapter
//   plot           adapter writeEn
//
// Optional feature macro: SQUARE_CLIP_EN -- masks plot for pixels beyond
// X_MAX / Y_MAX or carrying out of the port width; timing is unchanged.
// -----------------------------------------------------------------------------
module square_drawer #(
    parameter int unsigned SQ_W  = 4,
    parameter int unsigned SQ_H  = 4,
    parameter int unsigned X_MAX = 159,
    parameter int unsigned Y_MAX = 119
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] square_x,
    input  logic [6:0] square_y,
    input  logic [2:0] square_colour,
    output logic       ready,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot
);

    localparam int unsigned X_W  = 8;
    localparam int unsigned Y_W  = 7;
    localparam int unsigned C_W  = 3;
    localparam int unsigned CX_W = (SQ_W > 1) ? $clog2(SQ_W) : 1;
    localparam int unsigned CY_W = (SQ_H > 1) ? $clog2(SQ_H) : 1;

    // Reject illegal configurations at elaboration
    if (SQ_W == 0 || SQ_W > 16 || SQ_H == 0 || SQ_H > 16 ||
        X_MAX > 255 || Y_MAX > 127) begin : g_param_check
        $error("square_drawer: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [X_W-1:0]  base_x;
    logic [Y_W-1:0]  base_y;
    logic [C_W-1:0]  base_colour;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic            last_col;
    logic            last_row;
    logic            pix_on;

    assign last_col = (cx == CX_W'(SQ_W - 1));
    assign last_row = (cy == CY_W'(SQ_H - 1));

`ifdef SQUARE_CLIP_EN
    localparam int unsigned XF_W = X_W + 1;
    localparam int unsigned YF_W = Y_W + 1;

    // One extra bit keeps the carry so wrapped pixels are also masked
    logic [XF_W-1:0] full_x;
    logic [YF_W-1:0] full_y;

    assign full_x = {1'b0, base_x} + XF_W'(cx);
    assign full_y = {1'b0, base_y} + YF_W'(cy);
    assign pix_on = (full_x <= XF_W'(X_MAX)) && (full_y <= YF_W'(Y_MAX));
`else
    assign pix_on = 1'b1;
`endif

    // Control FSM with registered outputs. start is taken on the IDLE state,
    // so a held start relaunches immediately after DONE (SQ_W*SQ_H+2 period).
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            plot        <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            base_x      <= '0;
            base_y      <= '0;
            base_colour <= '0;
            cx          <= '0;
            cy          <= '0;
        end else begin
            done <= 1'b0;
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (start) begin
                        base_x      <= square_x;
                        base_y      <= square_y;
                        base_colour <= square_colour;
                        cx          <= '0;
                        cy          <= '0;
                        ready       <= 1'b0;
                        state       <= DRAW;
                    end
                end
                DRAW: begin
                    // Sums truncate to port width, wrapping at the screen edge
                    vga_x      <= base_x + X_W'(cx);
                    vga_y      <= base_y + Y_W'(cy);
                    vga_colour <= base_colour;
                    plot       <= pix_on;
                    if (last_col) begin
                        cx <= '0;
                        if (last_row) begin
                            state <= DONE;
                        end else begin
                            cy <= cy + CY_W'(1);
                        end
                    end else begin
                        cx <= cx + CX_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    ready <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_drawer.sv
// -----------------------------------------------------------------------------
// tb_square_drawer
// Directed bench for square_drawer (default 4x4, X_MAX=159, Y_MAX=119).
// Pixels are compared as one packed {plot, x, y, colour} word per cycle.
// -----------------------------------------------------------------------------
module tb_square_drawer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] square_x;
    logic [6:0] square_y;
    logic [2:0] square_colour;
    logic       ready;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;

    int tests  = 0;
    int failed = 0;

    square_drawer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .square_x      (square_x),
        .square_y      (square_y),
        .square_colour (square_colour),
        .ready         (ready),
        .done          (done),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .plot          (plot)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pix(input logic p, input int x, input int y, input int c);
        logic [7:0] xx;
        logic [6:0] yy;
        logic [2:0] cc;
        xx = 8'(x);
        yy = 7'(y);
        cc = 3'(c);
        return {13'd0, p, xx, yy, cc};
    endfunction

    function automatic logic [31:0] obs_pix();
        return {13'd0, plot, vga_x, vga_y, vga_colour};
    endfunction

    // Expect the 16 pixels of a square, starting one tick after acceptance
    task automatic draw_check(input string tag, input int bx, input int by, input int col);
        int  ex;
        int  ey;
        logic ep;
        for (int i = 0; i < 16; i++) begin
            tick();
            ex = bx + (i % 4);
            ey = by + (i / 4);
`ifdef SQUARE_CLIP_EN
            ep = (ex <= 159) && (ey <= 119);
`else
            ep = 1'b1;
`endif
            check($sformatf("%s_pix%0d", tag, i), obs_pix(), pix(ep, ex, ey, col));
            check($sformatf("%s_nodone%0d", tag, i), 32'(done), 32'd0);
        end
    endtask

    // Done cycle: done=1, plot=0, ready=0, pixel fields hold
    task automatic done_check(input string tag, input int lx, input int ly, input int col);
        tick();
        check({tag, "_done"}, {29'd0, done, plot, ready}, 32'b100);
        check({tag, "_hold"}, obs_pix(), pix(1'b0, lx, ly, col));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gap;
        int dones;
        int plots;
        logic seen;

        reset = 1'b1;
        start = 1'b0;
        square_x = '0;
        square_y = '0;
        square_colour = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_ctl", {29'd0, ready, done, plot}, 32'b100);
        check("reset_pix", {13'd0, 1'b0, vga_x, vga_y, vga_colour}, 32'd0);

        // 1: basic square at (1,53) colour 100
        square_x = 8'd1; square_y = 7'd53; square_colour = 3'b100; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_accept", {30'd0, ready, plot}, 32'b00);
        draw_check("t1", 1, 53, 4);
        done_check("t1", 4, 56, 4);
        tick();
        check("t1_ready", {30'd0, ready, done}, 32'b10);

        // 2+3: start held, inputs changed mid-draw, back-to-back squares
        square_x = 8'd50; square_y = 7'd10; square_colour = 3'b011; start = 1'b1;
        tick();
        square_x = 8'd20; square_y = 7'd30; square_colour = 3'b010;
        draw_check("t2", 50, 10, 3);
        // last pixel is 15 cycles after the first; find the next first pixel
        gap = 15;
        dones = 0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            gap++;
            if (done) dones++;
            if (plot) seen = 1'b1;
        end
        check("t3_gap", 32'(gap), 32'd18);
        check("t3_dones_between", 32'(dones), 32'd1);
        check("t3_second_first", obs_pix(), pix(1'b1, 20, 30, 2));
        start = 1'b0;
        plots = 1;
        dones = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (plot) plots++;
            if (done) begin
                dones++;
                seen = 1'b1;
            end
        end
        check("t3_second_plots", 32'(plots), 32'd16);
        check("t3_second_done", 32'(dones), 32'd1);
        check("t3_second_last", obs_pix(), pix(1'b0, 23, 33, 2));
        tick();
        check("t3_ready", {30'd0, ready, done}, 32'b10);

        // 4: reset on the 7th pixel
        square_x = 8'd10; square_y = 7'd20; square_colour = 3'b101; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("t4_pix7", obs_pix(), pix(1'b1, 12, 21, 5));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_reset_ctl", {29'd0, ready, done, plot}, 32'b100);
        check("t4_reset_pix", obs_pix(), 32'd0);
        dones = 0;
        plots = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) dones++;
            if (plot) plots++;
        end
        check("t4_no_done", 32'(dones), 32'd0);
        check("t4_no_plot", 32'(plots), 32'd0);

        // 5: square at the lower-right edge (clipped when the macro is on)
        square_x = 8'd158; square_y = 7'd118; square_colour = 3'b111; start = 1'b1;
        tick();
        start = 1'b0;
        draw_check("t5", 158, 118, 7);
        done_check("t5", 161, 121, 7);
        tick();

        // 5b: wrap past the port width in both x and y
        square_x = 8'd254; square_y = 7'd126; square_colour = 3'b001; start = 1'b1;
        tick();
        start = 1'b0;
        draw_check("t5w", 254, 126, 1);
        done_check("t5w", 257, 129, 1);
        tick();

        // 6: erase colour
        square_x = 8'd6; square_y = 7'd64; square_colour = 3'b000; start = 1'b1;
        tick();
        start = 1'b0;
        draw_check("t6", 6, 64, 0);
        done_check("t6", 9, 67, 0);
        tick();
        check("t6_ready", {30'd0, ready, done}, 32'b10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
